// File: rtl/audio_dma_arbiter_if.sv
// audio_dma_arbiter_if: memory fetch port between the audio DMA arbiter and the
// video memory arbiter.
//   fetch : one-cycle fetch strobe (arbiter -> memory)
//   tile  : memory select for the fetch, 0 = VRAM, 1 = TILE
//   addr  : fetch word address, held until the next fetch is issued
//   ack   : read complete (memory -> arbiter)
//   word  : read data, valid with ack
// Modports: master = arbiter side, slave = memory side.
interface audio_dma_arbiter_if;
  logic        fetch;
  logic        tile;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] word;

  modport master (output fetch, output tile, output addr, input ack, input word);
  modport slave  (input fetch, input tile, input addr, output ack, output word);
endinterface

// File: rtl/audio_dma_arbiter.sv
// audio_dma_arbiter: time-shares the single audio VRAM/TILE fetch port between
// NCHAN channel fetch requesters. Each DMA window opens on dma_start_i and issues
// up to SLOTS fetches, at most one per channel, and returns each fetched word to
// its owning channel. A fetch not acknowledged within TIMEOUT cycles is abandoned.
//
// Ports:
//   clk          system clock
//   reset_n_i    synchronous active-low reset
//   enable_i     audio enable; low aborts any window in progress
//   dma_start_i  one-cycle pulse opening a DMA window
//   req_i        per-channel fetch request (level)
//   tile_i       per-channel memory select (0 = VRAM, 1 = TILE)
//   addr_i       per-channel word address, channel i at [16*i +: 16]
//   grant_o      one-hot one-cycle pulse: channel served, word_o valid
//   word_o       fetched word, held between grants
//   busy_o       window active
//   overrun_o    one-cycle pulse: dma_start_i arrived while a window was active
//   timeout_o    one-cycle pulse: fetch abandoned
//   mem          memory fetch port (audio_dma_arbiter_if.master)
//
// Build option: define AUDIO_ARB_FIXED_PRIO_EN to replace round-robin selection
// with fixed priority (channel 0 highest).
module audio_dma_arbiter #(
  parameter int unsigned NCHAN   = 4,
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  dma_start_i,
  input  logic [NCHAN-1:0]      req_i,
  input  logic [NCHAN-1:0]      tile_i,
  input  logic [16*NCHAN-1:0]   addr_i,
  output logic [NCHAN-1:0]      grant_o,
  output logic [15:0]           word_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  timeout_o,
  audio_dma_arbiter_if.master   mem
);

  localparam int unsigned IdxW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {StIdle, StSelect, StIssue, StWait} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NCHAN-1:0]   served_q, served_d;
  logic [3:0]         slots_q, slots_d;
  logic [7:0]         timer_q, timer_d;
  logic [NCHAN-1:0]   grant_q, grant_d;
  logic [15:0]        word_q, word_d;
  logic               fetch_q, fetch_d;
  logic               tile_q, tile_d;
  logic [15:0]        addr_q, addr_d;
  logic               busy_q;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  // Channel selection
  logic [NCHAN-1:0]   cand;
  logic               found;
  logic [IdxW-1:0]    pick;
  logic [15:0]        pick_addr;
  int unsigned        c;

  always_comb begin
    cand  = req_i & ~served_q;
    found = 1'b0;
    pick  = '0;
    c     = 0;
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NCHAN; i++) begin
      c = i;
      if (!found && cand[c]) begin
        found = 1'b1;
        pick  = IdxW'(c);
      end
    end
`else
    // Scan starts one past the last granted channel and wraps.
    for (int unsigned i = 1; i <= NCHAN; i++) begin
      c = (32'(last_q) + i) % NCHAN;
      if (!found && cand[c]) begin
        found = 1'b1;
        pick  = IdxW'(c);
      end
    end
`endif
    pick_addr = addr_i[32'(pick)*16 +: 16];
  end

  // Next state and registered outputs
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    served_d  = served_q;
    slots_d   = slots_q;
    timer_d   = timer_q;
    grant_d   = '0;
    word_d    = word_q;
    fetch_d   = 1'b0;
    tile_d    = tile_q;
    addr_d    = addr_q;
    timeout_d = 1'b0;
    overrun_d = dma_start_i && (state_q != StIdle);

    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dma_start_i) begin
            served_d = '0;
            slots_d  = 4'(SLOTS);
            state_d  = StSelect;
          end
        end
        StSelect: begin
          if (!found || slots_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            idx_d   = pick;
            tile_d  = tile_i[pick];
            addr_d  = pick_addr;
            fetch_d = 1'b1;
            state_d = StIssue;
          end
        end
        StIssue, StWait: begin
          if (mem.ack) begin
            word_d          = mem.word;
            grant_d[idx_q]  = 1'b1;
            served_d[idx_q] = 1'b1;
            last_d          = idx_q;
            slots_d         = slots_q - 4'd1;
            state_d         = StSelect;
          end else if (state_q == StIssue) begin
            timer_d = '0;
            state_d = StWait;
          end else if (timer_q == 8'(TIMEOUT - 1)) begin
            // Abandoned fetch still uses up the channel and the slot.
            timeout_d       = 1'b1;
            served_d[idx_q] = 1'b1;
            slots_d         = slots_q - 4'd1;
            state_d         = StSelect;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(NCHAN - 1);
      idx_q     <= '0;
      served_q  <= '0;
      slots_q   <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      word_q    <= '0;
      fetch_q   <= 1'b0;
      tile_q    <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      served_q  <= served_d;
      slots_q   <= slots_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      word_q    <= word_d;
      fetch_q   <= fetch_d;
      tile_q    <= tile_d;
      addr_q    <= addr_d;
      busy_q    <= (state_d != StIdle);
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign word_o    = word_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;
  assign mem.fetch = fetch_q;
  assign mem.tile  = tile_q;
  assign mem.addr  = addr_q;

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// tb_audio_dma_arbiter: directed self-checking bench for audio_dma_arbiter.
// u_dut uses default parameters with a bench-driven memory; u_dut2 (SLOTS=2)
// has a zero-wait memory that answers every fetch with ~addr.
module tb_audio_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n, enable, enable2, dma_start;
  logic [3:0]  req, tile;
  logic [63:0] addr;
  logic [3:0]  grant, grant2;
  logic [15:0] word, word2;
  logic        busy, busy2, overrun, overrun2, timeout, timeout2;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  grant;
    logic [15:0] word;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp2_q[$];
  exp_t obs2_q[$];

  audio_dma_arbiter_if mem ();
  audio_dma_arbiter_if mem2 ();

  assign mem2.ack  = mem2.fetch;
  assign mem2.word = mem2.addr ^ 16'hFFFF;

  always #5 clk = ~clk;

  audio_dma_arbiter u_dut (
    .clk         (clk),
    .reset_n_i   (reset_n),
    .enable_i    (enable),
    .dma_start_i (dma_start),
    .req_i       (req),
    .tile_i      (tile),
    .addr_i      (addr),
    .grant_o     (grant),
    .word_o      (word),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .timeout_o   (timeout),
    .mem         (mem)
  );

  audio_dma_arbiter #(.NCHAN(4), .SLOTS(2), .TIMEOUT(3)) u_dut2 (
    .clk         (clk),
    .reset_n_i   (reset_n),
    .enable_i    (enable2),
    .dma_start_i (dma_start),
    .req_i       (req),
    .tile_i      (tile),
    .addr_i      (addr),
    .grant_o     (grant2),
    .word_o      (word2),
    .busy_o      (busy2),
    .overrun_o   (overrun2),
    .timeout_o   (timeout2),
    .mem         (mem2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
  endtask

  task automatic wait_fetch(input string tag);
    int n = 0;
    while (mem.fetch !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_fetch_seen"}, 32'(mem.fetch), 32'd1);
  endtask

  task automatic check_fetch(input string tag, input int ch);
    check({tag, "_addr"}, 32'(mem.addr), 32'(addr[16*ch +: 16]));
    check({tag, "_tile"}, 32'(mem.tile), 32'(tile[ch]));
  endtask

  // Acks the outstanding fetch now, then expects the grant exactly one edge later.
  task automatic ack_grant(input string tag, input int ch, input logic [15:0] w,
                           input bit drop);
    exp_t e;
    int   n = 0;
    mem.ack  = 1'b1;
    mem.word = w;
    sb_q.push_back('{4'(1 << ch), w});
    step();
    mem.ack  = 1'b0;
    mem.word = 16'hDEAD;
    while (grant === 4'b0 && n < 5) begin
      step();
      n++;
    end
    e = sb_q.pop_front();
    check({tag, "_grant"}, 32'(grant), 32'(e.grant));
    check({tag, "_word"}, 32'(word), 32'(e.word));
    check({tag, "_lat"}, 32'(n), 32'd0);
    if (drop) req[ch] = 1'b0;
  endtask

  task automatic run_dut2_window(input string tag, input int c0, input int c1);
    exp_t e;
    exp_t o;
    exp2_q.push_back('{4'(1 << c0), addr[16*c0 +: 16] ^ 16'hFFFF});
    exp2_q.push_back('{4'(1 << c1), addr[16*c1 +: 16] ^ 16'hFFFF});
    obs2_q.delete();
    pulse_start();
    repeat (12) begin
      if (grant2 !== 4'b0) obs2_q.push_back('{grant2, word2});
      step();
    end
    check({tag, "_ngrants"}, 32'(obs2_q.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      e = exp2_q.pop_front();
      o = (i < obs2_q.size()) ? obs2_q[i] : '0;
      check($sformatf("%s_grant%0d", tag, i), 32'(o.grant), 32'(e.grant));
      check($sformatf("%s_word%0d", tag, i), 32'(o.word), 32'(e.word));
    end
    check({tag, "_busy_end"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    enable2   = 1'b0;
    dma_start = 1'b0;
    req       = 4'b0;
    tile      = 4'b1010;
    addr      = {16'hC3C3, 16'h8282, 16'h4141, 16'h1010};
    mem.ack   = 1'b0;
    mem.word  = 16'h0;
    repeat (3) step();

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_fetch", 32'(mem.fetch), 32'd0);
    check("rst_addr", 32'(mem.addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({overrun, timeout}), 32'd0);
    reset_n = 1'b1;
    step();

    // Full window, all channels, one-wait ack
    req = 4'b1111;
    pulse_start();
    check("t1_busy_rise", 32'(busy), 32'd1);
    check("t1_no_early_fetch", 32'(mem.fetch), 32'd0);
    for (int ch = 0; ch < 4; ch++) begin
      wait_fetch($sformatf("t1_ch%0d", ch));
      check_fetch($sformatf("t1_ch%0d", ch), ch);
      step();
      check($sformatf("t1_ch%0d_strobe_1cyc", ch), 32'(mem.fetch), 32'd0);
      ack_grant($sformatf("t1_ch%0d", ch), ch, 16'h5000 + 16'(ch), 1'b1);
    end
    step();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_word_hold", 32'(word), 32'h5003);
    check("t1_grant_clear", 32'(grant), 32'd0);

    // Two requesters after last=3, then wrap from last=1; zero-wait acks,
    // requests held high in the second window
    req = 4'b0011;
    pulse_start();
    for (int ch = 0; ch < 2; ch++) begin
      wait_fetch($sformatf("t2a_ch%0d", ch));
      check_fetch($sformatf("t2a_ch%0d", ch), ch);
      step();
      ack_grant($sformatf("t2a_ch%0d", ch), ch, 16'h6000 + 16'(ch), 1'b1);
    end
    step();
    check("t2a_busy_fall", 32'(busy), 32'd0);
    req = 4'b0011;
    pulse_start();
    for (int ch = 0; ch < 2; ch++) begin
      wait_fetch($sformatf("t2b_ch%0d", ch));
      check_fetch($sformatf("t2b_ch%0d", ch), ch);
      ack_grant($sformatf("t2b_ch%0d", ch), ch, 16'h7000 + 16'(ch), 1'b0);
    end
    step();
    check("t2b_no_regrant", 32'(grant), 32'd0);
    check("t2b_busy_fall", 32'(busy), 32'd0);
    req = 4'b0;

    // Slot limit on the SLOTS=2 instance; the second window resumes after ch1
    enable  = 1'b0;
    enable2 = 1'b1;
    req     = 4'b1111;
    run_dut2_window("s2a", 0, 1);
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    run_dut2_window("s2b", 0, 1);
`else
    run_dut2_window("s2b", 2, 3);
`endif
    check("s2_tile_hold", 32'(mem2.tile), 32'd1);
    check("s2_flags", 32'({overrun2, timeout2, mem2.fetch}), 32'd0);
    enable2 = 1'b0;
    enable  = 1'b1;
    req     = 4'b0;
    step();

    // Timeout on ch2, then ch3 served
    req = 4'b1100;
    pulse_start();
    wait_fetch("t3_ch2");
    check_fetch("t3_ch2", 2);
    repeat (15) step();
    check("t3_timeout_early", 32'({timeout, grant}), 32'd0);
    step();
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_no_grant", 32'(grant), 32'd0);
    wait_fetch("t3_ch3");
    check_fetch("t3_ch3", 3);
    check("t3_timeout_pulse", 32'(timeout), 32'd0);
    step();
    ack_grant("t3_ch3", 3, 16'hA55A, 1'b1);
    req = 4'b0;
    step();
    check("t3_busy_fall", 32'(busy), 32'd0);

    // Overrun during WAIT leaves the window intact
    req = 4'b0001;
    pulse_start();
    wait_fetch("t4_ch0");
    check_fetch("t4_ch0", 0);
    step();
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    step();
    check("t4_overrun_pulse", 32'(overrun), 32'd0);
    ack_grant("t4_ch0", 0, 16'h0F0F, 1'b1);
    step();
    check("t4_busy_fall", 32'(busy), 32'd0);

    // Enable drop during WAIT; late ack ignored
    req = 4'b0010;
    pulse_start();
    wait_fetch("t5_ch1");
    check_fetch("t5_ch1", 1);
    step();
    enable = 1'b0;
    step();
    check("t5_abort_idle", 32'(busy), 32'd0);
    enable   = 1'b1;
    mem.ack  = 1'b1;
    mem.word = 16'hBEEF;
    step();
    mem.ack = 1'b0;
    check("t5_late_ack_grant", 32'(grant), 32'd0);
    step();
    check("t5_no_grant", 32'({grant, mem.fetch, busy}), 32'd0);
    check("t5_word_hold", 32'(word), 32'h0F0F);
    req = 4'b0;

    // Reset during ISSUE with a pending ack; restart at ch0
    req = 4'b1111;
    pulse_start();
    wait_fetch("t6_pre");
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    check_fetch("t6_pre", 0);
`else
    check_fetch("t6_pre", 1);
`endif
    reset_n = 1'b0;
    mem.ack = 1'b1;
    step();
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_fetch", 32'({mem.fetch, mem.tile}), 32'd0);
    check("t6_rst_addr", 32'(mem.addr), 32'd0);
    check("t6_rst_word_busy", 32'({word, busy}), 32'd0);
    reset_n = 1'b1;
    step();
    mem.ack = 1'b0;
    check("t6_pending_ack", 32'({grant, busy}), 32'd0);
    pulse_start();
    wait_fetch("t6_ch0");
    check_fetch("t6_ch0", 0);
    step();
    ack_grant("t6_ch0", 0, 16'h1234, 1'b1);
    req = 4'b0;
    step();
    check("t6_busy_fall", 32'(busy), 32'd0);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
